// File: rtl/twos_negate_seq_if.sv
// Handshake bundle for twos_negate_seq: operand/mode in, result/overflow out.
// master drives operands and accepts results; slave is the sign unit.
interface twos_negate_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/twos_negate_seq.sv
// Multi-cycle two's-complement sign unit: pass/negate/abs/negabs,
// CHUNK bits per cycle LSB first with a registered carry.
module twos_negate_seq #(
  parameter int WIDTH    = 16,
  parameter int CHUNK    = 4,
  parameter bit SATURATE = 1'b1
) (
  input logic clk,
  input logic rst_n,
  twos_negate_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX = ~MIN;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             inv;
  logic             ovf_pend;
  logic             carry;
  logic             vld;
  logic             ovf;
  logic             accept;
  logic             inv_n;
  logic [CHUNK:0]   sum;

  always_comb begin
    inv_n = 1'b0;
    unique case (bus.in_mode)
      2'b01:   inv_n = 1'b1;
      2'b10:   inv_n = bus.in_data[WIDTH-1];
      2'b11:   inv_n = ~bus.in_data[WIDTH-1];
      default: inv_n = 1'b0;
    endcase
  end

  assign bus.in_ready = (state == IDLE)
                      | ((state == DONE) & bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;

  // Conditional invert plus carry-in gives -x one chunk at a time
  assign sum = {1'b0, opnd[cnt*CHUNK +: CHUNK] ^ {CHUNK{inv}}}
             + {{CHUNK{1'b0}}, carry};

  assign bus.out_valid = vld;
  assign bus.out_data  = res;
  assign bus.out_ovf   = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opnd     <= '0;
      res      <= '0;
      cnt      <= '0;
      inv      <= 1'b0;
      ovf_pend <= 1'b0;
      carry    <= 1'b0;
      vld      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        BUSY: begin
          res[cnt*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
          carry <= sum[CHUNK];
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
            vld   <= 1'b1;
            ovf   <= ovf_pend;
            if (SATURATE && ovf_pend) res <= MAX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld   <= 1'b0;
            ovf   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Accept overrides the DONE->IDLE return for back-to-back operands
      if (accept) begin
        opnd     <= bus.in_data;
        inv      <= inv_n;
        ovf_pend <= inv_n & (bus.in_data == MIN);
        carry    <= inv_n;
        cnt      <= '0;
        state    <= BUSY;
      end
    end
  end
endmodule

// File: tb/tb_twos_negate_seq.sv
// Directed bench for twos_negate_seq: defaults, SATURATE=0,
// and 32/8 and 8/8 sweeps against an integer golden model.
module tb_twos_negate_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  twos_negate_seq_if #(.WIDTH(16)) a_if ();
  twos_negate_seq_if #(.WIDTH(16)) b_if ();
  twos_negate_seq_if #(.WIDTH(32)) c_if ();
  twos_negate_seq_if #(.WIDTH(8))  d_if ();

  assign b_if.in_valid  = a_if.in_valid;
  assign b_if.in_data   = a_if.in_data;
  assign b_if.in_mode   = a_if.in_mode;
  assign b_if.out_ready = a_if.out_ready;

  twos_negate_seq #(.WIDTH(16), .CHUNK(4), .SATURATE(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  twos_negate_seq #(.WIDTH(16), .CHUNK(4), .SATURATE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  twos_negate_seq #(.WIDTH(32), .CHUNK(8), .SATURATE(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if.slave));
  twos_negate_seq #(.WIDTH(8), .CHUNK(8), .SATURATE(1'b1)) u_d (
    .clk(clk), .rst_n(rst_n), .bus(d_if.slave));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void golden(input int w, input logic [31:0] x,
                                 input logic [1:0] m, input bit sat,
                                 output logic [31:0] r, output logic o);
    longint md, mx, mn, xs, t;
    md = longint'(1) << w;
    mx = md / 2 - 1;
    mn = -(md / 2);
    xs = longint'(x) & (md - 1);
    if (xs > mx) xs = xs - md;
    case (m)
      2'd0: t = xs;
      2'd1: t = -xs;
      2'd2: t = (xs < 0) ? -xs : xs;
      default: t = (xs < 0) ? xs : -xs;
    endcase
    o = (t > mx) || (t < mn);
    if (o && sat) t = mx;
    r = 32'(t & (md - 1));
  endfunction

  task automatic run_a(input logic [15:0] x, input logic [1:0] m,
                       input logic [15:0] ea, input logic oa,
                       input logic [15:0] eb, input logic ob);
    int lat;
    @(negedge clk);
    chk("a_rdy", a_if.in_ready, 1);
    a_if.in_valid = 1'b1;
    a_if.in_data = x;
    a_if.in_mode = m;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    a_if.in_data = ~x;
    a_if.in_mode = ~m;
    lat = 0;
    while (!a_if.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("a_lat", lat, 4);
    chk("a_data", a_if.out_data, ea);
    chk("a_ovf", a_if.out_ovf, oa);
    chk("b_data", b_if.out_data, eb);
    chk("b_ovf", b_if.out_ovf, ob);
    @(posedge clk); #1;
  endtask

  task automatic run_c(input logic [31:0] x, input logic [1:0] m);
    logic [31:0] r;
    logic o;
    int lat;
    golden(32, x, m, 1'b1, r, o);
    @(negedge clk);
    c_if.in_valid = 1'b1;
    c_if.in_data = x;
    c_if.in_mode = m;
    @(posedge clk); #1;
    c_if.in_valid = 1'b0;
    c_if.in_data = ~x;
    lat = 0;
    while (!c_if.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("c_lat", lat, 4);
    chk("c_data", c_if.out_data, r);
    chk("c_ovf", c_if.out_ovf, o);
    @(posedge clk); #1;
  endtask

  task automatic run_d(input logic [7:0] x, input logic [1:0] m);
    logic [31:0] r;
    logic o;
    int lat;
    golden(8, {24'd0, x}, m, 1'b1, r, o);
    @(negedge clk);
    d_if.in_valid = 1'b1;
    d_if.in_data = x;
    d_if.in_mode = m;
    @(posedge clk); #1;
    d_if.in_valid = 1'b0;
    d_if.in_data = ~x;
    lat = 0;
    while (!d_if.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("d_lat", lat, 1);
    chk("d_data", {24'd0, d_if.out_data}, r);
    chk("d_ovf", d_if.out_ovf, o);
    @(posedge clk); #1;
  endtask

  initial begin
    int k, cyc, got, last;
    bit acc;
    logic [15:0] exp16;
    a_if.in_valid = 1'b0; a_if.in_data = '0;
    a_if.in_mode = 2'd0; a_if.out_ready = 1'b1;
    c_if.in_valid = 1'b0; c_if.in_data = '0;
    c_if.in_mode = 2'd0; c_if.out_ready = 1'b1;
    d_if.in_valid = 1'b0; d_if.in_data = '0;
    d_if.in_mode = 2'd0; d_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", a_if.in_ready, 1);
    chk("rst_vld", a_if.out_valid, 0);
    chk("rst_data", a_if.out_data, 0);
    chk("rst_ovf", a_if.out_ovf, 0);

    run_a(16'h0005, 2'b01, 16'hFFFB, 0, 16'hFFFB, 0);
    run_a(16'h0000, 2'b01, 16'h0000, 0, 16'h0000, 0);
    run_a(16'h8000, 2'b01, 16'h7FFF, 1, 16'h8000, 1);
    run_a(16'h8000, 2'b10, 16'h7FFF, 1, 16'h8000, 1);
    run_a(16'h8000, 2'b11, 16'h8000, 0, 16'h8000, 0);
    run_a(16'h8000, 2'b00, 16'h8000, 0, 16'h8000, 0);
    run_a(16'hFFFB, 2'b10, 16'h0005, 0, 16'h0005, 0);
    run_a(16'h0005, 2'b10, 16'h0005, 0, 16'h0005, 0);
    run_a(16'h0005, 2'b11, 16'hFFFB, 0, 16'hFFFB, 0);
    run_a(16'hFFFB, 2'b11, 16'hFFFB, 0, 16'hFFFB, 0);
    run_a(16'h1234, 2'b00, 16'h1234, 0, 16'h1234, 0);
    run_a(16'h0100, 2'b01, 16'hFF00, 0, 16'hFF00, 0);

    // Backpressure: hold result in DONE for 10 cycles
    @(negedge clk);
    a_if.out_ready = 1'b0;
    a_if.in_valid = 1'b1;
    a_if.in_data = 16'h0003;
    a_if.in_mode = 2'b01;
    @(posedge clk); #1;
    a_if.in_data = 16'h0042;
    k = 0;
    while (!a_if.out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_lat", k, 4);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_data", a_if.out_data, 16'hFFFD);
      chk("bp_vld", a_if.out_valid, 1);
      chk("bp_rdy", a_if.in_ready, 0);
    end
    @(negedge clk);
    a_if.in_valid = 1'b0;
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop", a_if.out_valid, 0);
    chk("bp_idle", a_if.in_ready, 1);

    // Streaming: 8 operands with in_valid held high
    k = 0; cyc = 0; got = 0; last = 0;
    @(negedge clk);
    a_if.in_valid = 1'b1;
    a_if.in_mode = 2'b01;
    a_if.in_data = 16'h0107;
    while (got < 8 && cyc < 200) begin
      acc = a_if.in_valid && a_if.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (a_if.out_valid) begin
        exp16 = 16'h0000 - (16'h0100 * 16'(got + 1) + 16'h0007);
        chk("thr_data", a_if.out_data, exp16);
        if (got > 0) chk("thr_gap", cyc - last, 5);
        last = cyc;
        got++;
      end
      @(negedge clk);
      if (acc) begin
        k++;
        if (k < 8) a_if.in_data = 16'h0100 * 16'(k + 1) + 16'h0007;
        else a_if.in_valid = 1'b0;
      end
    end
    chk("thr_cnt", got, 8);
    chk("thr_acc", k, 8);
    repeat (2) @(posedge clk);

    // Reset during BUSY chunk 2
    @(negedge clk);
    a_if.in_valid = 1'b1;
    a_if.in_data = 16'h0005;
    a_if.in_mode = 2'b01;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mr_vld", a_if.out_valid, 0);
    chk("mr_data", a_if.out_data, 0);
    chk("mr_bdata", b_if.out_data, 0);
    chk("mr_rdy", a_if.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(16'h0009, 2'b01, 16'hFFF7, 0, 16'hFFF7, 0);

    run_c(32'h8000_0000, 2'b01);
    run_c(32'h8000_0000, 2'b10);
    run_c(32'h8000_0000, 2'b11);
    run_c(32'h0000_0000, 2'b01);
    repeat (8) run_c($urandom, 2'($urandom_range(0, 3)));

    run_d(8'h80, 2'b01);
    run_d(8'h80, 2'b10);
    run_d(8'h80, 2'b11);
    run_d(8'h80, 2'b00);
    repeat (8) run_d(8'($urandom), 2'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/twos_negate_seq.md
# twos_negate_seq

Parametrised, multi-cycle two's-complement sign unit for the fixed-point eigenvalue datapath. It accepts a signed WIDTH-bit operand with a per-transaction mode: pass, negate, absolute value, or negative absolute value. It processes CHUNK bits per cycle, LSB first, with a registered carry, so wide words close timing without a full-width incrementer. Optional saturation handles the most-negative input, and valid/ready handshakes on both sides let it sit between the matrix-element buffers and the shift/subtract stages.

## Interface
- WIDTH, 16: operand width in bits. Must be ≥ 2.
- CHUNK, 4: bits processed per cycle. WIDTH % CHUNK must be 0. NCHUNK = WIDTH/CHUNK.
- SATURATE, 1: 1 = an overflowing result is replaced by MAX; 0 = the result wraps.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  the operand and mode are valid.
- in_ready  out  1  the block can accept an operand this cycle.
- in_data  in  WIDTH  signed operand.
- in_mode  in  2  00 pass, 01 negate (−x), 10 abs (|x|), 11 negabs (−|x|).
- out_valid  out  1  the result is valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  signed result.
- out_ovf  out  1  the true result is not representable in WIDTH bits.

## Operation
- MIN = 1 followed by WIDTH−1 zeros. MAX = 0 followed by WIDTH−1 ones.
- FSM states: IDLE, BUSY, DONE.
- Accept condition: in_valid & in_ready.
- in_ready is combinational:
  - 1 in IDLE.
  - 1 in DONE when out_ready is 1.
  - 0 in BUSY.
- On accept, the block captures in_data, a per-operation invert flag inv, and ovf_pending:
  - inv: mode 01 → 1; mode 10 → sign bit; mode 11 → ~sign bit; mode 00 → 0.
  - ovf_pending = inv & (in_data == MIN).
  - The block then enters BUSY with chunk counter cnt = 0 and carry = inv.
- Each BUSY cycle:
  - Chunk cnt is computed as (captured_chunk ^ {CHUNK{inv}}) + carry.
  - The CHUNK-bit sum is written to bits [cnt*CHUNK +: CHUNK] of out_data.
  - The carry-out is registered and cnt increments.
- When cnt = NCHUNK−1, the block enters DONE, sets out_valid = 1 and out_ovf = ovf_pending.
  - If SATURATE = 1 and ovf_pending = 1, out_data is forced to MAX on the same edge.
- Mode 11 never overflows, because −MIN stays MIN after the conditional negate yields MIN. This falls out of the inv rule: MIN has sign bit 1, so inv = 0.
- In DONE, out_data and out_ovf hold stable until out_valid & out_ready.
- On a DONE handshake:
  - If a new accept occurs in the same cycle, the block goes straight to BUSY.
  - Otherwise it returns to IDLE and out_valid drops.
- in_mode and in_data are sampled only on accept. Later changes are ignored.
- Carry between chunks comes only from the carry register. There is no full-width adder.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE, cnt = 0, carry = 0.
  - out_valid = 0, out_data = 0, out_ovf = 0.
  - in_ready therefore reads 1 once rst_n is high.
- Reset during BUSY or DONE aborts the transaction. No partial result is ever presented.
- Latency: out_valid rises NCHUNK rising edges after the accept edge. WIDTH=16, CHUNK=4 gives 4 cycles; CHUNK=WIDTH gives 1 cycle.
- Throughput with out_ready held at 1: one result every NCHUNK+1 cycles. The extra cycle is the DONE state, in which the next accept also happens.
- Backpressure: with out_ready = 0, the block stays in DONE indefinitely with in_ready = 0.
- out_data bits written in BUSY may change before out_valid. Downstream must qualify out_data with out_valid.

## Test plan
- Basic negate and latency (defaults): accept 0x0005 with mode 01 → out_data 0xFFFB, out_ovf 0, out_valid rising exactly 4 edges after accept. 0x0000 with mode 01 → 0x0000, exercising carry through all chunks.
- Overflow: 0x8000 with mode 01 or mode 10, SATURATE=1 → 0x7FFF with ovf 1. Same input with SATURATE=0 → 0x8000 with ovf 1. 0x8000 with mode 11 → 0x8000 with ovf 0.
- Abs and negabs: mode 10 with 0xFFFB → 0x0005; mode 10 with 0x0005 → 0x0005. Mode 11 with 0x0005 → 0xFFFB; mode 11 with 0xFFFB → 0xFFFB. Mode 00 with 0x1234 → 0x1234.
- Handshake: hold out_ready = 0 for 10 cycles in DONE → out_data stays stable and in_ready = 0. With out_ready = 1 and in_valid held high for 8 operands → a result every 5 cycles, none dropped or duplicated, and the order preserved.
- Reset mid-operation: assert rst_n low during BUSY chunk 2 → out_valid 0 and out_data 0 immediately. After release, the first new accept yields the correct result.
- Parameter sweep: WIDTH=32 with CHUNK=8 and WIDTH=8 with CHUNK=8, using random operands and modes → results match the golden model, latency equals NCHUNK, and out_ovf is set only for MIN with inv = 1.
